// File: rtl/seq_digit_player_if.sv
// seq_digit_player_if
//   Control and display bus of the sequence player.
//   master : drives en/oneshot/restart/dir, observes digit/index/wrap/done
//   slave  : the player itself
//   en      - advance prescaler/sequence when high
//   oneshot - 1 = stop at end of table, 0 = loop
//   restart - synchronous return to start position
//   dir     - 0 = forward, 1 = reverse
//   digit   - table entry at current index
//   index   - current table index
//   wrap    - one-cycle pulse when the loop wraps
//   done    - one-shot playback finished (sticky)
interface seq_digit_player_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic             en;
  logic             oneshot;
  logic             restart;
  logic             dir;
  logic [WIDTH-1:0] digit;
  logic [IW-1:0]    index;
  logic             wrap;
  logic             done;

  modport master (
    output en, oneshot, restart, dir,
    input  digit, index, wrap, done
  );

  modport slave (
    input  en, oneshot, restart, dir,
    output digit, index, wrap, done
  );
endinterface

// File: rtl/seq_digit_player.sv
// seq_digit_player
//   Steps through a compile-time table of DEPTH digits (WIDTH bits each)
//   and presents the current entry on the display bus. Enable, step
//   prescaler (DIV enabled cycles per step), loop/one-shot modes and a
//   synchronous restart are supported.
//   Optional feature macro: SEQ_PLAYER_REVERSE_EN -- when defined the dir
//   input selects reverse playback; otherwise dir is ignored and only the
//   forward stepping logic is built.
// Ports
//   clk   - clock, all state updates on rising edge
//   reset - synchronous, active-high reset
//   bus   - seq_digit_player_if.slave (en, oneshot, restart, dir in;
//           digit, index, wrap, done out)
module seq_digit_player #(
  parameter int                     WIDTH = 4,
  parameter int                     DEPTH = 8,
  parameter int                     DIV   = 1,
  parameter logic [DEPTH*WIDTH-1:0] SEQ   = {4'd5, 4'd1, 4'd6, 4'd0,
                                             4'd4, 4'd0, 4'd0, 4'd2}
) (
  input  logic                clk,
  input  logic                reset,
  seq_digit_player_if.slave   bus
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [IW-1:0] IDX_MAX = IW'(DEPTH - 1);
  localparam logic [PW-1:0] PC_LAST = PW'(DIV - 1);

  logic [IW-1:0]    r_index;
  logic [PW-1:0]    r_pc;
  logic             r_done;
  logic             r_wrap;

  logic [IW-1:0]    w_start;
  logic [IW-1:0]    w_last;
  logic [IW-1:0]    w_next;
  logic [WIDTH-1:0] w_tab [DEPTH];

  // Start/last positions and the neighbour index for the effective
  // direction. w_next is only used when r_index != w_last, so it never
  // leaves 0..DEPTH-1 even for non-power-of-two DEPTH.
`ifdef SEQ_PLAYER_REVERSE_EN
  always_comb begin
    w_start = bus.dir ? IDX_MAX : '0;
    w_last  = bus.dir ? '0 : IDX_MAX;
    w_next  = bus.dir ? (r_index - 1'b1) : (r_index + 1'b1);
  end
`else
  logic w_unused_dir;
  assign w_unused_dir = bus.dir;
  always_comb begin
    w_start = '0;
    w_last  = IDX_MAX;
    w_next  = r_index + 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      // reset always restarts forward from entry 0
      r_index <= '0;
      r_pc    <= '0;
      r_done  <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (bus.restart) begin
      r_index <= w_start;
      r_pc    <= '0;
      r_done  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (bus.en && !r_done) begin
        if (r_pc != PC_LAST) begin
          r_pc <= r_pc + 1'b1;
        end else begin
          r_pc <= '0;
          if (r_index != w_last) begin
            r_index <= w_next;
          end else if (!bus.oneshot) begin
            r_index <= w_start;
            r_wrap  <= 1'b1;
          end else begin
            // park on the last entry; it has already been shown a full period
            r_done  <= 1'b1;
          end
        end
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_tab
    assign w_tab[g] = SEQ[g*WIDTH +: WIDTH];
  end

  assign bus.digit = w_tab[r_index];
  assign bus.index = r_index;
  assign bus.wrap  = r_wrap;
  assign bus.done  = r_done;
endmodule

// File: tb/tb_seq_digit_player.sv
module tb_seq_digit_player;
  logic clk = 1'b0;
  logic reset0, reset1;
  always #5 clk = ~clk;

  seq_digit_player_if #(.WIDTH(4), .DEPTH(8)) bus0 ();
  seq_digit_player_if #(.WIDTH(4), .DEPTH(8)) bus1 ();

  seq_digit_player #(.WIDTH(4), .DEPTH(8), .DIV(1)) u_dut0 (
    .clk(clk), .reset(reset0), .bus(bus0)
  );
  seq_digit_player #(.WIDTH(4), .DEPTH(8), .DIV(3)) u_dut1 (
    .clk(clk), .reset(reset1), .bus(bus1)
  );

  typedef struct {
    int    idx;
    int    wrap;
    int    done;
    string tag;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   seqv [8] = '{2, 0, 0, 4, 0, 6, 1, 5};
  int   n_chk = 0;
  int   n_err = 0;

  task automatic compare(input exp_t e, input int idx, input int dig,
                         input int wr, input int dn);
    n_chk++;
    if (idx != e.idx || dig != seqv[e.idx] || wr != e.wrap || dn != e.done) begin
      n_err++;
      $display("FAIL %s: got idx=%0d digit=%0d wrap=%0d done=%0d, want idx=%0d digit=%0d wrap=%0d done=%0d",
               e.tag, idx, dig, wr, dn, e.idx, seqv[e.idx], e.wrap, e.done);
    end
  endtask

  // monitors: outputs are presented every cycle; check just after each edge
  always @(posedge clk) begin
    #1;
    if (q0.size() > 0) begin
      exp_t e;
      e = q0.pop_front();
      compare(e, int'(bus0.index), int'(bus0.digit), int'(bus0.wrap), int'(bus0.done));
    end
    if (q1.size() > 0) begin
      exp_t e;
      e = q1.pop_front();
      compare(e, int'(bus1.index), int'(bus1.digit), int'(bus1.wrap), int'(bus1.done));
    end
  end

  // drive one cycle on dut0 and queue the state expected after the edge
  task automatic cyc0(input logic rst, input logic rs, input logic e,
                      input logic os, input logic d,
                      input int eidx, input int ewr, input int edn,
                      input string tag);
    exp_t x;
    reset0 = rst; bus0.restart = rs; bus0.en = e;
    bus0.oneshot = os; bus0.dir = d;
    x.idx = eidx; x.wrap = ewr; x.done = edn; x.tag = tag;
    q0.push_back(x);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cyc1(input logic rst, input logic e, input int eidx,
                      input string tag);
    exp_t x;
    reset1 = rst; bus1.restart = 1'b0; bus1.en = e;
    bus1.oneshot = 1'b0; bus1.dir = 1'b0;
    x.idx = eidx; x.wrap = 0; x.done = 0; x.tag = tag;
    q1.push_back(x);
    @(posedge clk);
    @(negedge clk);
  endtask

  // expected index after each step of the direction test
  int rev_dir  [14] = '{1,1,1, 0, 1,1,1,1,1,1, 1,1,1,1};
`ifdef SEQ_PLAYER_REVERSE_EN
  int rev_idx  [14] = '{6,5,4, 5, 4,3,2,1,0,7, 6,5,4,3};
  int rev_wr   [14] = '{0,0,0, 0, 0,0,0,0,0,1, 0,0,0,0};
  int rev_start = 7;
`else
  int rev_idx  [14] = '{1,2,3, 4, 5,6,7,0,1,2, 3,4,5,6};
  int rev_wr   [14] = '{0,0,0, 0, 0,0,0,1,0,0, 0,0,0,0};
  int rev_start = 0;
`endif

  // DIV=3: every 3rd enabled cycle, with en low for 2 cycles mid-count
  int d3_en  [18] = '{1,1,1, 1,1,1, 1,1,1, 1,0,0,1,1, 1,1,1,1};
  int d3_idx [18] = '{0,0,1, 1,1,2, 2,2,3, 3,3,3,3,4, 4,4,5,5};

  initial begin
    reset0 = 1'b1; reset1 = 1'b1;
    bus0.restart = 1'b0; bus0.en = 1'b0; bus0.oneshot = 1'b0; bus0.dir = 1'b0;
    bus1.restart = 1'b0; bus1.en = 1'b0; bus1.oneshot = 1'b0; bus1.dir = 1'b0;
    @(negedge clk);

    // reset state
    cyc0(1, 0, 1, 0, 0, 0, 0, 0, "reset");
    // loop forward: 2,0,0,4,0,6,1,5,2...; wrap only when index returns to 0
    for (int k = 0; k < 10; k++)
      cyc0(0, 0, 1, 0, 0, (k + 1) % 8, ((k + 1) % 8 == 0) ? 1 : 0, 0, "loop");
    // en low freezes
    cyc0(0, 0, 0, 0, 0, 2, 0, 0, "en_low_a");
    cyc0(0, 0, 0, 0, 0, 2, 0, 0, "en_low_b");
    // restart wins over en
    cyc0(0, 1, 1, 0, 0, 0, 0, 0, "restart_vs_en");

    // one-shot from reset
    cyc0(1, 0, 0, 1, 0, 0, 0, 0, "os_reset");
    for (int k = 1; k <= 7; k++)
      cyc0(0, 0, 1, 1, 0, k, 0, 0, "os_step");
    cyc0(0, 0, 1, 1, 0, 7, 0, 1, "os_done");
    cyc0(0, 0, 1, 1, 0, 7, 0, 1, "os_hold");
    cyc0(0, 0, 1, 0, 1, 7, 0, 1, "os_frozen");
    cyc0(0, 1, 1, 1, 0, 0, 0, 0, "os_restart");
    cyc0(0, 0, 1, 1, 0, 1, 0, 0, "os_after");

    // direction test, starting from a restart with dir=1
    cyc0(0, 1, 0, 0, 1, rev_start, 0, 0, "dir_restart");
    for (int k = 0; k < 14; k++)
      cyc0(0, 0, 1, 0, rev_dir[k][0], rev_idx[k], rev_wr[k], 0, "dir_step");
    // reset and restart together with dir=1: reset wins
    cyc0(1, 1, 1, 0, 1, 0, 0, 0, "reset_restart");
    cyc0(0, 0, 0, 0, 1, 0, 0, 0, "reset_restart_hold");

    // prescaler instance
    cyc1(1, 1, 0, "d3_reset");
    for (int k = 0; k < 18; k++)
      cyc1(0, d3_en[k][0], d3_idx[k], "d3_step");

    // let the monitors drain, bounded
    for (int k = 0; k < 20 && (q0.size() > 0 || q1.size() > 0); k++)
      @(negedge clk);
    n_chk++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending, want 0", q0.size() + q1.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish");
    $fatal(1);
  end
endmodule

// File: doc/seq_digit_player.md
# seq_digit_player

Parametrised sequence player: steps through a compile-time table of DEPTH digits of WIDTH bits and presents the current digit on a display bus. Adds enable, a step prescaler, loop/one-shot modes, synchronous restart and optional reverse playback. It sits between the system clock domain and the digit-display / 7-segment driver logic in the design.

## Interface
- WIDTH, 4, bits per digit.
- DEPTH, 8, number of table entries (≥2).
- DIV, 1, enabled cycles per step (≥1).
- SEQ, {4'd5,4'd1,4'd6,4'd0,4'd4,4'd0,4'd0,4'd2}, packed DEPTH*WIDTH table; entry i at bits [i*WIDTH +: WIDTH], entry 0 in LSBs (default plays 2,0,0,4,0,6,1,5).
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  advance prescaler/sequence when high; freeze when low.
- oneshot  input  1  1 = stop at end of table, 0 = loop.
- restart  input  1  synchronous return to start position.
- dir  input  1  0 = forward, 1 = reverse (functional only with SEQ_PLAYER_REVERSE_EN).
- digit  output  WIDTH  table entry at current index.
- index  output  $clog2(DEPTH)  current table index.
- wrap  output  1  one-cycle pulse on loop wrap.
- done  output  1  one-shot playback finished (sticky).

## Operation
- State: index register, prescaler counter pc (0..DIV-1), done flag, wrap flag.
- digit = SEQ entry at index, combinational from index register; no extra latency.
- Start position S: 0 when effective dir=0, DEPTH-1 when effective dir=1 (sampled at the restart/reset edge; reset always uses dir=0, i.e. S=0).
- Last position L: DEPTH-1 forward, 0 reverse (evaluated with the current dir).
- Priority per edge: reset > restart > en. Below, "step" = en && !done && pc==DIV-1.
- reset: index=0, pc=0, done=0, wrap=0.
- restart: index=S, pc=0, done=0, wrap=0; en ignored that cycle.
- en && !done: pc increments; at DIV-1 it returns to 0 and a step occurs.
- Step, index≠L: index ±1 per dir; wrap=0.
- Step, index==L, oneshot=0: index=S for current dir; wrap=1 for that one cycle.
- Step, index==L, oneshot=1: index holds, done=1, pc=0.
- done=1: index and pc frozen until restart/reset; en, dir, oneshot changes have no effect.
- en=0: index, pc, done hold; wrap=0.
- dir change mid-run: next step moves from current index in new direction; pc unaffected.
- oneshot change mid-run: evaluated only at the step leaving L.
- Index arithmetic never produces values ≥DEPTH (non-power-of-two DEPTH must wrap explicitly).

## Timing
- Reset values: index=0, digit=SEQ[0], wrap=0, done=0.
- Latency from step-enabling cycle to new index/digit: 1 clock.
- With en held high and DIV=d, index changes every d cycles; loop period DEPTH*d cycles.
- wrap is high exactly in the cycle the wrapped index is first visible.
- done rises one step period after index first reaches L (L shown for a full period).
- restart and reset take effect at the same edge they are sampled; outputs updated next cycle.

## Configuration
- SEQ_PLAYER_REVERSE_EN defined: dir input functional as above.
- Not defined: dir ignored, effective dir=0 everywhere (S=0, L=DEPTH-1); only forward stepping logic is built.

## Test plan
- Reset, en=1, oneshot=0, DIV=1, dir=0: digit sequence 2,0,0,4,0,6,1,5,2…; wrap high only on the cycle index returns to 0.
- DIV=3, en=1: index changes every 3rd cycle; en low for 2 cycles mid-count extends that interval to exactly 5 cycles.
- oneshot=1 from reset: index reaches 7 (digit 5), holds one step period, then done=1; index stays 7 with en high; restart → index 0, done 0, next step 1.
- With SEQ_PLAYER_REVERSE_EN, dir=1 at restart: index 7,6,…,0,7; wrap on 0→7; dir flip at index 4 → next index 5.
- Without macro, dir=1: behaviour identical to dir=0 cycle for cycle.
- reset and restart asserted together mid-run with dir=1: index 0, pc 0, done 0, wrap 0.
